// File: rtl/arvi_m_pkg.sv
// Shared types and helpers for the external RV32M multiply/divide unit.
package arvi_m_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned M_ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } m_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIN,
        S_DONE
    } m_state_t;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                            input logic s);
        return s ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/m_div_iter.sv
// One step of an unsigned restoring divider.
module m_div_iter
    import arvi_m_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shl;
    logic [XLEN:0] diff;

    always_comb begin
        shl  = {rem_i, quo_i[XLEN-1]};
        diff = shl - {1'b0, div_i};
        if (!diff[XLEN]) begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shl[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/m_ext_unit.sv
// Iterative RV32M responder: latches one request, runs 32 shift-add or
// shift-subtract steps, then pulses ack with the registered result.
module m_ext_unit
    import arvi_m_pkg::*;
#(
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_f3,
    output logic [XLEN-1:0] o_res,
    output logic            o_ack
);

    localparam logic [4:0] LAST = 5'(M_ITER - 1);

    m_state_t        state_q, state_d;
    m_op_t           op_q, op_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            pneg_q, pneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] res_q, res_d;

    m_op_t           op_in;
    logic            s1, s2;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, ovf, fast_hit;
    logic [63:0]     fprod;
    logic [XLEN-1:0] fast_res;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] dv_rem, dv_quo;
    logic [63:0]     prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fin_res;

    m_div_iter u_div (
        .rem_i (hi_q),
        .quo_i (lo_q),
        .div_i (m_q),
        .rem_o (dv_rem),
        .quo_o (dv_quo)
    );

    // Operand signedness follows the op; MULHSU never treats rs2 as negative.
    always_comb begin
        op_in = m_op_t'(i_f3);
        s1 = i_rs1[XLEN-1] &
             (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        s2 = i_rs2[XLEN-1] &
             (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        a_mag = mag(i_rs1, s1);
        b_mag = mag(i_rs2, s2);
        div_zero = op_in[2] && (i_rs2 == '0);
        ovf = (op_in inside {OP_DIV, OP_REM}) &&
              (i_rs1 == 32'h8000_0000) && (i_rs2 == '1);
        fast_hit = div_zero || ovf || (FAST_MUL && !op_in[2]);
        fprod = {32'b0, a_mag} * {32'b0, b_mag};
        if (s1 ^ s2) fprod = ~fprod + 64'd1;
        if (div_zero)
            fast_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : i_rs1;
        else if (ovf)
            fast_res = (op_in == OP_DIV) ? 32'h8000_0000 : '0;
        else if (op_in == OP_MUL)
            fast_res = fprod[31:0];
        else
            fast_res = fprod[63:32];
    end

    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        prod_s = {hi_q, lo_q};
        if (pneg_q) prod_s = ~prod_s + 64'd1;
        quo_s = mag(lo_q, pneg_q);
        rem_s = mag(hi_q, rneg_q);
        unique case (op_q)
            OP_MUL:                        fin_res = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_s[63:32];
            OP_DIV, OP_DIVU:               fin_res = quo_s;
            default:                       fin_res = rem_s;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pneg_d  = pneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_en) begin
                    op_d   = op_in;
                    cnt_d  = '0;
                    hi_d   = '0;
                    pneg_d = s1 ^ s2;
                    rneg_d = s1;
                    m_d    = op_in[2] ? b_mag : a_mag;
                    lo_d   = op_in[2] ? a_mag : b_mag;
                    if (fast_hit) begin
                        res_d   = fast_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (!i_en) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        hi_d = dv_rem;
                        lo_d = dv_quo;
                    end else begin
                        hi_d = sum[XLEN:1];
                        lo_d = {sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST) state_d = S_FIN;
                end
            end
            S_FIN: begin
                res_d   = fin_res;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pneg_q  <= pneg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

    assign o_ack = (state_q == S_DONE);
    assign o_res = o_ack ? res_q : '0;

endmodule
